disk_ii_stream: RTL and testbench
=================================

# disk_ii_stream

Rotating-media emulation stage directly downstream of the per-track buffer. It walks a 6656-byte (13×512) track image at the Disk II byte rate, 32 µs per byte. In read mode it feeds bytes into the controller data latch; in write mode it stores CPU-supplied bytes back into the buffer. It also drives the buffer's `active` input so dirty-track flushes wait until the motor stops.

## Interface
Parameters:
- TRACK_LEN, 6656: bytes per track; position wraps at TRACK_LEN-1.
- BYTE_US, 32: cen_1m pulses per byte.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cen_1m  in  1  1 MHz clock enable, single-clk pulse
- motor_on  in  1  drive motor enabled
- write_mode  in  1  controller Q7: 1 = write, 0 = read
- track_ready  in  1  buffer holds a mounted image
- track_busy  in  1  buffer is loading or saving a track
- rd_strobe  in  1  one-clk pulse when the CPU reads the data latch
- wr_strobe  in  1  one-clk pulse when the CPU loads the write register
- wr_data  in  8  byte to write
- latch_out  out  8  data latch seen by the CPU; bit 7 = valid
- ram_addr  out  13  buffer address, registered, equals position
- ram_do  in  8  buffer read data, one-clk registered latency
- ram_di  out  8  buffer write data
- ram_we  out  1  buffer write enable, one-clk pulse
- active  out  1  motor_on & track_ready, registered

## Operation
- Counters:
  - bit_cnt, 5 bits: counts cen_1m pulses while motor_on.
  - pos, 13 bits: track position.
  - On cen_1m with bit_cnt==BYTE_US-1: bit_cnt←0 and pos←(pos==TRACK_LEN-1 ? 0 : pos+1). This is the byte boundary event.
- motor_on=0: bit_cnt and pos freeze, no buffer accesses, latch holds its value.
- wr_reg (8 bits): loaded from wr_data on wr_strobe in any mode.
- FSM states IDLE, ADDR, DATA:
  - IDLE→ADDR on a boundary event if track_ready & ~track_busy. Otherwise the boundary is skipped: no access and no latch update, but rotation still advances.
  - ADDR→DATA unconditionally. In write mode ADDR asserts ram_we=1 with ram_di=wr_reg.
  - DATA→IDLE. In read mode DATA latches latch_out←ram_do.
  - write_mode is sampled in ADDR. A mode change mid-access takes effect at the next boundary.
- Latch clear: rd_strobe with latch_out[7]=1 clears latch_out to 8'h00. A DATA-state load on the same clk wins (new byte, unmodified).
- Write-mode latch: latch_out is not updated by the FSM. An unreloaded wr_reg is re-written at each boundary (sync-byte behaviour).
- Same-clk conflicts:
  - wr_strobe in the ADDR clk: the old wr_reg value is written; the new value is used at the next boundary.
  - track_busy rising while in ADDR/DATA: the access completes and no retry occurs.
- Position is not reset on track change. The new track's data appears at the current pos.
- Reset mid-access: FSM to IDLE immediately and ram_we deasserted the same edge. No partial write is extended.

## Timing
- Reset values: latch_out=0, ram_addr=0, ram_di=0, ram_we=0, active=0, pos=0, bit_cnt=0, wr_reg=0, state IDLE.
- Boundary at edge T0 (pos and ram_addr update):
  - T1: state ADDR; ram_we high for one clk in write mode.
  - Read mode: buffer output valid after T1; latch_out updated at T2.
  - Next boundary at T0 + 32 µs.
- Byte period is exactly BYTE_US cen_1m pulses. One rotation = 6656×32 µs = 212.992 ms.
- active follows motor_on & track_ready with 1 clk latency.
- rd_strobe clear takes effect at the next edge. The cleared latch is visible 1 clk after the strobe.

## Test plan
- Image byte[k]=k[7:0], motor_on, read mode, cen_1m every 4 clk → latch_out=8'h80|…; the byte at pos 5 is 8'h05 latched 2 clk after the 5th boundary; 32 cen_1m pulses between latch loads.
- Run pos to 6655 → next boundary gives pos=0, ram_addr=0, latch=byte[0]; no address 6656 ever driven.
- write_mode=1, wr_strobe wr_data=8'hD5 → exactly one ram_we pulse per boundary, ram_di=8'hD5, ram_addr=pos. With no reload, the next boundary writes 8'hD5 again.
- track_busy=1 across 3 boundaries → no ram_we, latch unchanged, pos advances by 3; after busy falls, the next boundary resumes accesses.
- rd_strobe on the same clk as the DATA latch load → latch holds the new byte with bit 7 set; rd_strobe one clk later → 8'h00.
- reset asserted in the ADDR clk during write → ram_we=0 on the following clk, all outputs at reset values, no further writes until motor_on and the next boundary.

Source files
------------

// File: rtl/disk_ii_stream.sv
// Disk II rotating-media emulation: walks a track image at the byte rate, feeding the
// controller data latch in read mode and writing the CPU byte back in write mode.
module disk_ii_stream #(
  parameter int unsigned TRACK_LEN = 6656,
  parameter int unsigned BYTE_US   = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cen_1m,
  input  logic        motor_on,
  input  logic        write_mode,
  input  logic        track_ready,
  input  logic        track_busy,
  input  logic        rd_strobe,
  input  logic        wr_strobe,
  input  logic [7:0]  wr_data,
  output logic [7:0]  latch_out,
  output logic [12:0] ram_addr,
  input  logic [7:0]  ram_do,
  output logic [7:0]  ram_di,
  output logic        ram_we,
  output logic        active
);

  localparam logic [4:0]  BitLast = 5'(BYTE_US - 1);
  localparam logic [12:0] PosLast = 13'(TRACK_LEN - 1);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  state_e      state_q, state_d;
  logic [4:0]  bit_cnt_q;
  logic [12:0] pos_q;
  logic [7:0]  wr_reg_q;
  logic [7:0]  latch_q, latch_d;
  logic        wmode_q;
  logic        active_q;
  logic        boundary;

  assign boundary = motor_on & cen_1m & (bit_cnt_q == BitLast);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      pos_q     <= '0;
      wr_reg_q  <= '0;
      latch_q   <= '0;
      wmode_q   <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      if (motor_on && cen_1m) begin
        if (bit_cnt_q == BitLast) begin
          bit_cnt_q <= '0;
          pos_q     <= (pos_q == PosLast) ? 13'd0 : pos_q + 13'd1;
        end else begin
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
      end
      state_q <= state_d;
      // Mode is frozen for the remainder of the access once the address cycle is seen.
      if (state_q == StAddr) wmode_q <= write_mode;
      if (wr_strobe) wr_reg_q <= wr_data;
      latch_q  <= latch_d;
      active_q <= motor_on & track_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    latch_d = latch_q;
    ram_we  = 1'b0;
    unique case (state_q)
      StIdle: if (boundary && track_ready && !track_busy) state_d = StAddr;
      StAddr: begin
        state_d = StData;
        ram_we  = write_mode;
      end
      StData:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (rd_strobe && latch_q[7]) latch_d = 8'h00;
    // A fresh byte takes priority over a CPU read clearing the latch.
    if (state_q == StData && !wmode_q) latch_d = ram_do | 8'h80;
  end

  assign latch_out = latch_q;
  assign ram_addr  = pos_q;
  assign ram_di    = wr_reg_q;
  assign active    = active_q;

endmodule

// File: tb/tb_disk_ii_stream.sv
// Randomized bench for disk_ii_stream against a byte-event model of the rotating track,
// with a behavioural one-cycle-latency track buffer.
module tb_disk_ii_stream;

  localparam int TL = 6656;
  localparam int BU = 3;

  logic        clk = 1'b0;
  logic        reset, cen_1m, motor_on, write_mode, track_ready, track_busy;
  logic        rd_strobe, wr_strobe;
  logic [7:0]  wr_data, latch_out, ram_do, ram_di;
  logic [12:0] ram_addr;
  logic        ram_we, active;

  disk_ii_stream #(.TRACK_LEN(TL), .BYTE_US(BU)) dut (
    .clk(clk), .reset(reset), .cen_1m(cen_1m), .motor_on(motor_on),
    .write_mode(write_mode), .track_ready(track_ready), .track_busy(track_busy),
    .rd_strobe(rd_strobe), .wr_strobe(wr_strobe), .wr_data(wr_data),
    .latch_out(latch_out), .ram_addr(ram_addr), .ram_do(ram_do), .ram_di(ram_di),
    .ram_we(ram_we), .active(active)
  );

  always #5 clk = ~clk;

  // Track buffer: unwritten locations hold their address low byte.
  logic [7:0] mem [8192];
  bit         wrote [8192];
  always @(posedge clk) begin
    ram_do <= wrote[ram_addr] ? mem[ram_addr] : ram_addr[7:0];
    if (ram_we) begin
      mem[ram_addr]   <= ram_di;
      wrote[ram_addr] <= 1'b1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte-time counting and a per-access age since its boundary.
  logic [7:0] img [TL];
  int         m_cnt, m_pos, m_age, m_acc_pos;
  logic [7:0] m_latch, m_wr, m_rd_val;
  logic       m_active, m_acc_wm, m_wrapped;

  task automatic model_step();
    logic was_idle, load;
    if (reset) begin
      m_cnt = 0; m_pos = 0; m_age = 0; m_latch = 8'h00; m_wr = 8'h00; m_active = 1'b0;
      return;
    end
    was_idle = (m_age == 0);
    load     = 1'b0;
    if (m_age == 1) begin
      m_rd_val = img[m_acc_pos];
      if (write_mode) img[m_acc_pos] = m_wr;
      m_acc_wm = write_mode;
      m_age    = 2;
    end else if (m_age == 2) begin
      load  = !m_acc_wm;
      m_age = 0;
    end
    if (load) m_latch = m_rd_val | 8'h80;
    else if (rd_strobe && m_latch[7]) m_latch = 8'h00;
    if (wr_strobe) m_wr = wr_data;
    m_active = motor_on & track_ready;
    if (motor_on && cen_1m) begin
      m_cnt++;
      if (m_cnt == BU) begin
        m_cnt = 0;
        if (m_pos == TL - 1) m_wrapped = 1'b1;
        m_pos = (m_pos + 1) % TL;
        if (was_idle && track_ready && !track_busy) begin
          m_age     = 1;
          m_acc_pos = m_pos;
        end
      end
    end
  endtask

  task automatic drive(input int ph);
    cen_1m    = (ph == 4) ? ~cen_1m : (cen_1m ? 1'b0 : ($urandom_range(0, 2) != 0));
    rd_strobe = ($urandom_range(0, 3) == 0);
    wr_data   = 8'($urandom);
    reset     = 1'b0;
    case (ph)
      1, 2: begin
        motor_on    = 1'b1;
        track_ready = 1'b1;
        write_mode  = (ph == 2);
        wr_strobe   = ($urandom_range(0, (ph == 2) ? 19 : 5) == 0);
        track_busy  = track_busy ? ($urandom_range(0, 40) != 0) : ($urandom_range(0, 60) == 0);
      end
      3: begin
        wr_strobe = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 150) == 0) motor_on = ~motor_on;
        if ($urandom_range(0, 200) == 0) track_ready = ~track_ready;
        if ($urandom_range(0, 7) == 0) write_mode = ~write_mode;
        track_busy = track_busy ? ($urandom_range(0, 30) != 0) : ($urandom_range(0, 80) == 0);
        reset      = ($urandom_range(0, 300) == 0);
      end
      default: begin
        motor_on = 1'b1; track_ready = 1'b1; write_mode = 1'b0; track_busy = 1'b0;
        wr_strobe = 1'b0;
      end
    endcase
  endtask

  task automatic run_cycle(input int ph);
    logic exp_we;
    @(negedge clk);
    if (ph != 0) drive(ph);
    #1;
    exp_we = (m_age == 1) && write_mode;
    check("ram_we", ram_we, exp_we);
    if (exp_we) check("ram_di", ram_di, m_wr);
    @(posedge clk);
    #1;
    model_step();
    check("latch_out", latch_out, m_latch);
    check("ram_addr", ram_addr, m_pos);
    check("active", active, m_active);
  endtask

  initial begin
    for (int k = 0; k < TL; k++) img[k] = k[7:0];
    m_wrapped = 1'b0; m_age = 0; m_acc_wm = 1'b0; m_rd_val = 8'h00; m_acc_pos = 0;
    reset = 1'b1; cen_1m = 1'b0; motor_on = 1'b1; write_mode = 1'b1; track_ready = 1'b1;
    track_busy = 1'b0; rd_strobe = 1'b0; wr_strobe = 1'b0; wr_data = 8'h00;
    for (int i = 0; i < 3; i++) run_cycle(0);
    check("reset_ram_we", ram_we, 1'b0);
    check("reset_ram_di", ram_di, 8'h00);
    for (int i = 0; i < 3000; i++) run_cycle(1);
    for (int i = 0; i < 3000; i++) run_cycle(2);
    for (int i = 0; i < 6000; i++) run_cycle(3);
    begin
      int budget = 60000;
      m_wrapped = 1'b0;
      while (!m_wrapped && budget > 0) begin
        run_cycle(4);
        budget--;
      end
      if (!m_wrapped) check("wrap_timeout", 0, 1);
      for (int i = 0; i < 20; i++) run_cycle(4);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
